multipump_scheduler: RTL and testbench



---
 rtl/multipump_sched_pkg.sv | 16 +
 rtl/multipump_scheduler_rr_pick2.sv | 36 +++
 rtl/multipump_scheduler.sv | 117 +++++++++++
 tb/tb_multipump_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multipump_sched_pkg.sv
// multipump_sched_pkg: shared types and helpers for the multipump scheduler.
package multipump_sched_pkg;
    localparam int ID_W = 8;
    typedef logic [ID_W-1:0] id_t;
    typedef struct packed {
        logic v;
        id_t  id;
    } lane_tag_t;
    typedef enum logic {
        LANE_AB = 1'b0,
        LANE_CD = 1'b1
    } lane_e;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/multipump_scheduler_rr_pick2.sv
// rr_pick2: combinational round-robin picker returning the first two valid requesters from ptr.
module rr_pick2
    import multipump_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_w0,
    output logic [NREQ-1:0] o_w1,
    output logic            o_f0,
    output logic            o_f1
);
    always_comb begin
        logic f0, f1;
        f0 = 1'b0;
        f1 = 1'b0;
        o_w0 = '0;
        o_w1 = '0;
        // Walk distances from ptr so the scan wraps naturally past NREQ-1.
        for (int k = 0; k < NREQ; k++)
            for (int i = 0; i < NREQ; i++)
                if (i_valid[i] && ((i + NREQ - int'(i_ptr)) % NREQ) == k) begin
                    if (!f0) begin
                        o_w0[i] = 1'b1;
                        f0 = 1'b1;
                    end else if (!f1) begin
                        o_w1[i] = 1'b1;
                        f1 = 1'b1;
                    end
                end
        o_f0 = f0;
        o_f1 = f1;
    end
endmodule

// File: rtl/multipump_scheduler.sv
// multipump_scheduler: grants up to two requesters per cycle onto a double-pumped multiplier
// and routes each product back to its issuer after the multiplier latency.
module multipump_scheduler
    import multipump_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SIZE    = 32,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*SIZE-1:0]     req_a,
    input  logic [NREQ*SIZE-1:0]     req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [SIZE-1:0]          mp_inA,
    output logic [SIZE-1:0]          mp_inB,
    output logic [SIZE-1:0]          mp_inC,
    output logic [SIZE-1:0]          mp_inD,
    input  logic [2*SIZE-1:0]        mp_outAxB,
    input  logic [2*SIZE-1:0]        mp_outCxD,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [NREQ*2*SIZE-1:0]   rsp_data
);
    localparam int PW = id_width(NREQ);
    localparam int RW = 2 * SIZE;

    logic [PW-1:0]   r_ptr, w_i0, w_i1, w_ptr_nxt;
    logic [NREQ-1:0] w_w0, w_w1, w_hit_ab, w_hit_cd, r_rsp_valid;
    logic            w_f0, w_f1;
    logic [SIZE-1:0] w_a0, w_b0, w_a1, w_b1, r_mp_a, r_mp_b, r_mp_c, r_mp_d;
    logic [NREQ*RW-1:0] r_rsp_data;
    lane_tag_t [LATENCY:0][1:0] r_tag;

    rr_pick2 #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_w0    (w_w0),
        .o_w1    (w_w1),
        .o_f0    (w_f0),
        .o_f1    (w_f1)
    );

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
        return (x == PW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        w_i0 = '0;
        w_i1 = '0;
        w_a0 = '0;
        w_b0 = '0;
        w_a1 = '0;
        w_b1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_w0[i]) begin
                w_i0 = PW'(i);
                w_a0 = req_a[i*SIZE +: SIZE];
                w_b0 = req_b[i*SIZE +: SIZE];
            end
            if (w_w1[i]) begin
                w_i1 = PW'(i);
                w_a1 = req_a[i*SIZE +: SIZE];
                w_b1 = req_b[i*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        w_hit_ab = '0;
        w_hit_cd = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_hit_ab[i] = r_tag[LATENCY][LANE_AB].v && r_tag[LATENCY][LANE_AB].id == id_t'(i);
            w_hit_cd[i] = r_tag[LATENCY][LANE_CD].v && r_tag[LATENCY][LANE_CD].id == id_t'(i);
        end
    end

    assign w_ptr_nxt = w_f1 ? wrap_inc(w_i1) : w_f0 ? wrap_inc(w_i0) : r_ptr;
    assign req_ready = reset ? '0 : (w_w0 | w_w1);
    assign mp_inA    = r_mp_a;
    assign mp_inB    = r_mp_b;
    assign mp_inC    = r_mp_c;
    assign mp_inD    = r_mp_d;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_mp_a      <= '0;
            r_mp_b      <= '0;
            r_mp_c      <= '0;
            r_mp_d      <= '0;
            r_tag       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_mp_a <= w_a0;
            r_mp_b <= w_b0;
            r_mp_c <= w_a1;
            r_mp_d <= w_b1;
            r_tag[0][LANE_AB] <= '{v: w_f0, id: id_t'(w_i0)};
            r_tag[0][LANE_CD] <= '{v: w_f1, id: id_t'(w_i1)};
            for (int k = 1; k <= LATENCY; k++)
                r_tag[k] <= r_tag[k-1];
            // Lanes never carry the same id, so at most one write per requester.
            for (int i = 0; i < NREQ; i++) begin
                r_rsp_valid[i] <= w_hit_ab[i] | w_hit_cd[i];
                if (w_hit_ab[i])
                    r_rsp_data[i*RW +: RW] <= mp_outAxB;
                else if (w_hit_cd[i])
                    r_rsp_data[i*RW +: RW] <= mp_outCxD;
            end
        end
    end
endmodule

// File: tb/tb_multipump_scheduler.sv
// tb_multipump_scheduler: randomized and directed checks of the scheduler against a
// round-robin/queue reference model, with a one-cycle multiplier model driving the products.
module tb_multipump_scheduler;
    localparam int NREQ = 4, SIZE = 32, LATENCY = 1, W = 2 * SIZE;

    logic                 clk = 1'b0, reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0, req_ready, rsp_valid;
    logic [NREQ*SIZE-1:0] req_a = '0, req_b = '0;
    logic [SIZE-1:0]      mp_inA, mp_inB, mp_inC, mp_inD;
    logic [W-1:0]         mp_outAxB, mp_outCxD;
    logic [NREQ*W-1:0]    rsp_data;

    multipump_scheduler #(.NREQ(NREQ), .SIZE(SIZE), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mp_inA    (mp_inA),
        .mp_inB    (mp_inB),
        .mp_inC    (mp_inC),
        .mp_inD    (mp_inD),
        .mp_outAxB (mp_outAxB),
        .mp_outCxD (mp_outCxD),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    // Multiplier with one cycle of latency.
    always @(posedge clk) begin
        mp_outAxB <= W'(mp_inA) * W'(mp_inB);
        mp_outCxD <= W'(mp_inC) * W'(mp_inD);
    end

    int n_chk = 0, n_pass = 0, cyc = 0, m_ptr = 0;
    logic [W-1:0]    m_data [NREQ];
    logic [SIZE-1:0] m_a, m_b, m_c, m_d, n_a, n_b, n_c, n_d;
    logic [NREQ-1:0] last_g = '0;
    int              q_cyc[$], q_req[$];
    logic [W-1:0]    q_val[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [SIZE-1:0] opa(input int i);
        return req_a[i*SIZE +: SIZE];
    endfunction

    function automatic logic [SIZE-1:0] opb(input int i);
        return req_b[i*SIZE +: SIZE];
    endfunction

    task automatic set_req(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        req_a[i*SIZE +: SIZE] = a;
        req_b[i*SIZE +: SIZE] = b;
    endtask

    function automatic logic [SIZE-1:0] rnd_op();
        int s;
        s = $urandom_range(0, 3);
        return (s == 0) ? '1 : (s == 1) ? SIZE'($urandom_range(0, 15)) : SIZE'($urandom);
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        q_cyc.delete();
        q_req.delete();
        q_val.delete();
        for (int i = 0; i < NREQ; i++) m_data[i] = '0;
        {m_a, m_b, m_c, m_d, n_a, n_b, n_c, n_d} = '0;
    endtask

    // Called mid-cycle: checks the current outputs, then books the grants of the coming edge.
    task automatic check_cycle();
        int w0, w1;
        logic [NREQ-1:0] g, ev;
        w0 = -1;
        w1 = -1;
        g  = '0;
        ev = '0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) begin
                if (w0 < 0) w0 = i;
                else if (w1 < 0) w1 = i;
            end
        end
        if (w0 >= 0) g[w0] = 1'b1;
        if (w1 >= 0) g[w1] = 1'b1;
        chk("req_ready", W'(req_ready), W'(g));
        chk("mp_inA", W'(mp_inA), W'(m_a));
        chk("mp_inB", W'(mp_inB), W'(m_b));
        chk("mp_inC", W'(mp_inC), W'(m_c));
        chk("mp_inD", W'(mp_inD), W'(m_d));
        while (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
            ev[q_req[0]] = 1'b1;
            m_data[q_req[0]] = q_val[0];
            void'(q_cyc.pop_front());
            void'(q_req.pop_front());
            void'(q_val.pop_front());
        end
        chk("rsp_valid", W'(rsp_valid), W'(ev));
        for (int i = 0; i < NREQ; i++)
            chk($sformatf("rsp_data[%0d]", i), rsp_data[i*W +: W], m_data[i]);
        n_a = (w0 >= 0) ? opa(w0) : '0;
        n_b = (w0 >= 0) ? opb(w0) : '0;
        n_c = (w1 >= 0) ? opa(w1) : '0;
        n_d = (w1 >= 0) ? opb(w1) : '0;
        for (int j = 0; j < 2; j++) begin
            int w;
            w = (j == 0) ? w0 : w1;
            if (w >= 0) begin
                q_cyc.push_back(cyc + LATENCY + 2);
                q_req.push_back(w);
                q_val.push_back(W'(opa(w)) * W'(opb(w)));
            end
        end
        if (w0 >= 0) m_ptr = (((w1 >= 0) ? w1 : w0) + 1) % NREQ;
        last_g = g;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        cyc++;
        {m_a, m_b, m_c, m_d} = {n_a, n_b, n_c, n_d};
        #1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_rsp_data", W'(rsp_data != '0), W'(0));
        chk("rst_mp_in", W'(mp_inA | mp_inB | mp_inC | mp_inD), W'(0));
        chk("rst_ready", W'(req_ready), W'(0));
        reset = 1'b0;

        // Single requester 2: 7 x 9.
        set_req(2, 7, 9);
        req_valid = 4'b0100;
        #1 chk("t1_ready", W'(req_ready), W'(4'b0100));
        step();
        req_valid = '0;
        chk("t1_inA", W'(mp_inA), W'(7));
        chk("t1_inCD", W'(mp_inC | mp_inD), W'(0));
        step();
        step();
        chk("t1_rsp_valid", W'(rsp_valid), W'(4'b0100));
        chk("t1_rsp_data", rsp_data[2*W +: W], W'(63));

        // ptr is now 3: requesters 0 and 3 -> W0=3 (AB), W1=0 (CD).
        set_req(0, 11, 12);
        set_req(3, 13, 14);
        req_valid = 4'b1001;
        #1 chk("wrap_ready", W'(req_ready), W'(4'b1001));
        step();
        chk("wrap_inA", W'(mp_inA), W'(13));
        chk("wrap_inC", W'(mp_inC), W'(11));
        set_req(0, 21, 22);
        set_req(1, 2, 3);
        set_req(2, 4, 5);
        set_req(3, 23, 24);
        req_valid = 4'b1111;
        #1 chk("wrap_next_ready", W'(req_ready), W'(4'b0110));
        step();
        req_valid = 4'b1001;
        step();
        req_valid = '0;
        repeat (4) step();

        // Requester 1 back to back: 3 x 4 then 5 x 6.
        set_req(1, 3, 4);
        req_valid = 4'b0010;
        step();
        set_req(1, 5, 6);
        step();
        req_valid = '0;
        step();
        chk("b2b_v0", W'(rsp_valid), W'(4'b0010));
        chk("b2b_d0", rsp_data[1*W +: W], W'(12));
        step();
        chk("b2b_v1", W'(rsp_valid), W'(4'b0010));
        chk("b2b_d1", rsp_data[1*W +: W], W'(30));

        // Full-width operands.
        set_req(0, '1, '1);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        step();
        chk("max_data", rsp_data[0 +: W], 64'hFFFFFFFE00000001);
        repeat (2) step();

        // Reset with two operations in flight.
        for (int i = 0; i < NREQ; i++) set_req(i, SIZE'(i + 5), SIZE'(i + 7));
        req_valid = 4'b0011;
        step();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("mid_rst_rsp_data", W'(rsp_data != '0), W'(0));
        chk("mid_rst_mp_in", W'(mp_inA | mp_inB | mp_inC | mp_inD), W'(0));
        chk("mid_rst_ready", W'(req_ready), W'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        req_valid = 4'b1111;
        #1;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("rr_ready_%0d", j), W'(req_ready), W'((j % 2 == 0) ? 4'b0011 : 4'b1100));
            step();
            if (j < 2) chk($sformatf("post_rst_quiet_%0d", j), W'(rsp_valid), W'(0));
            else chk($sformatf("rr_two_rsp_%0d", j), W'($countones(rsp_valid)), W'(2));
            for (int i = 0; i < NREQ; i++) if (last_g[i]) set_req(i, rnd_op(), rnd_op());
            #1;
        end

        // Randomized traffic: granted or idle requesters re-roll, others hold.
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] || last_g[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    set_req(i, rnd_op(), rnd_op());
                end
            step();
        end
        req_valid = '0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
